// File: rtl/pcs_rx_pkg.sv
// Shared definitions for the PCS receive path: FSM state codes, r_type
// classes and the CGMII characters and blocks used on the receive side.
package pcs_rx_pkg;

    localparam int LEN_RX_DATA = 64;
    localparam int LEN_RX_CTRL = 8;
    localparam int LEN_R_TYPE  = 4;
    localparam int LEN_ERR_CNT = 16;

    typedef enum logic [2:0] {
        RX_INIT = 3'd0,
        RX_C    = 3'd1,
        RX_D    = 3'd2,
        RX_T    = 3'd3,
        RX_E    = 3'd4
    } rx_state_t;

    typedef enum logic [2:0] {
        BLK_D,
        BLK_S,
        BLK_C,
        BLK_T,
        BLK_E
    } blk_class_t;

    localparam logic [3:0] R_TYPE_D = 4'b1000;
    localparam logic [3:0] R_TYPE_S = 4'b0100;
    localparam logic [3:0] R_TYPE_C = 4'b0010;
    localparam logic [3:0] R_TYPE_T = 4'b0001;

    localparam logic [7:0] CGMII_IDLE  = 8'h07;
    localparam logic [7:0] CGMII_START = 8'hFB;
    localparam logic [7:0] CGMII_TERM  = 8'hFD;
    localparam logic [7:0] CGMII_ERROR = 8'hFE;
    localparam logic [7:0] CGMII_SEQ   = 8'h9C;

    localparam logic [63:0] LBLOCK_R_DATA = 64'h9C000001_9C000001;
    localparam logic [7:0]  LBLOCK_R_CTRL = 8'h88;
    localparam logic [63:0] EBLOCK_R_DATA = {8{CGMII_ERROR}};
    localparam logic [7:0]  EBLOCK_R_CTRL = 8'hFF;

    // Anything other than an exact one-hot code is an error block.
    function automatic blk_class_t classify(input logic [3:0] rt);
        case (rt)
            R_TYPE_D: return BLK_D;
            R_TYPE_S: return BLK_S;
            R_TYPE_C: return BLK_C;
            R_TYPE_T: return BLK_T;
            default:  return BLK_E;
        endcase
    endfunction

endpackage

// File: rtl/rx_decode_fsm_if.sv
// Block-decoder-to-CGMII bus of the receive FSM; master drives the decoded
// blocks and link status, slave returns the CGMII stream and debug state.
interface rx_decode_fsm_if;
    import pcs_rx_pkg::*;

    logic                   i_enable;
    logic [LEN_RX_DATA-1:0] i_rx_data;
    logic [LEN_RX_CTRL-1:0] i_rx_ctrl;
    logic [LEN_R_TYPE-1:0]  i_r_type;
    logic                   i_block_lock;
    logic                   i_hi_ber;
    logic [LEN_RX_DATA-1:0] o_rx_data;
    logic [LEN_RX_CTRL-1:0] o_rx_ctrl;
    logic                   o_valid;
    logic [2:0]             o_state;
    logic [LEN_ERR_CNT-1:0] o_err_count;

    modport master (
        output i_enable, i_rx_data, i_rx_ctrl, i_r_type, i_block_lock, i_hi_ber,
        input  o_rx_data, o_rx_ctrl, o_valid, o_state, o_err_count
    );

    modport slave (
        input  i_enable, i_rx_data, i_rx_ctrl, i_r_type, i_block_lock, i_hi_ber,
        output o_rx_data, o_rx_ctrl, o_valid, o_state, o_err_count
    );

endinterface

// File: rtl/rx_lookahead_stage.sv
// One-block lookahead register: holds the block under decision while the
// following block's type arrives; a flush empties it during lock loss.
module rx_lookahead_stage
    import pcs_rx_pkg::*;
(
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_load,
    input  logic                   i_flush,
    input  logic [LEN_RX_DATA-1:0] i_data,
    input  logic [LEN_RX_CTRL-1:0] i_ctrl,
    input  logic [LEN_R_TYPE-1:0]  i_type,
    output logic [LEN_RX_DATA-1:0] o_data,
    output logic [LEN_RX_CTRL-1:0] o_ctrl,
    output logic [LEN_R_TYPE-1:0]  o_type,
    output logic                   o_full
);

    logic [LEN_RX_DATA-1:0] r_data;
    logic [LEN_RX_CTRL-1:0] r_ctrl;
    logic [LEN_R_TYPE-1:0]  r_type;
    logic                   r_full;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_data <= '0;
            r_ctrl <= '0;
            r_type <= '0;
            r_full <= 1'b0;
        end else if (i_flush) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data;
            r_ctrl <= i_ctrl;
            r_type <= i_type;
            r_full <= 1'b1;
        end
    end

    assign o_data = r_data;
    assign o_ctrl = r_ctrl;
    assign o_type = r_type;
    assign o_full = r_full;

endmodule

// File: rtl/rx_decode_fsm.sv
// 64b/66b receive control FSM: validates the staged block against the state
// and the next block's type, substituting LBLOCK_R / EBLOCK_R as needed.
module rx_decode_fsm
    import pcs_rx_pkg::*;
(
    input  logic          i_clock,
    input  logic          i_reset,
    rx_decode_fsm_if.slave bus
);

    localparam logic [LEN_ERR_CNT-1:0] ERR_ONE = LEN_ERR_CNT'(1);

    logic                   w_lock_loss;
    logic [LEN_RX_DATA-1:0] w_stage_data;
    logic [LEN_RX_CTRL-1:0] w_stage_ctrl;
    logic [LEN_R_TYPE-1:0]  w_stage_type;
    logic                   w_stage_full;
    blk_class_t             w_cur;
    blk_class_t             w_nxt;
    logic                   w_t_ok;
    rx_state_t              w_next_state;

    rx_state_t              r_state;
    logic [LEN_RX_DATA-1:0] r_rx_data;
    logic [LEN_RX_CTRL-1:0] r_rx_ctrl;
    logic                   r_valid;
    logic [LEN_ERR_CNT-1:0] r_err_count;

    assign w_lock_loss = !bus.i_block_lock || bus.i_hi_ber;

    rx_lookahead_stage u_stage (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_load  (bus.i_enable && !w_lock_loss),
        .i_flush (w_lock_loss),
        .i_data  (bus.i_rx_data),
        .i_ctrl  (bus.i_rx_ctrl),
        .i_type  (bus.i_r_type),
        .o_data  (w_stage_data),
        .o_ctrl  (w_stage_ctrl),
        .o_type  (w_stage_type),
        .o_full  (w_stage_full)
    );

    assign w_cur  = classify(w_stage_type);
    assign w_nxt  = classify(bus.i_r_type);
    // A terminate is only trusted when the following block starts or idles.
    assign w_t_ok = (w_nxt == BLK_S) || (w_nxt == BLK_C);

    always_comb begin
        w_next_state = RX_E;
        case (r_state)
            RX_INIT, RX_C, RX_T: begin
                if (w_cur == BLK_C)      w_next_state = RX_C;
                else if (w_cur == BLK_S) w_next_state = RX_D;
            end
            RX_D: begin
                if (w_cur == BLK_D)                 w_next_state = RX_D;
                else if (w_cur == BLK_T && w_t_ok)  w_next_state = RX_T;
            end
            RX_E: begin
                if (w_cur == BLK_C)                 w_next_state = RX_C;
                else if (w_cur == BLK_D)            w_next_state = RX_D;
                else if (w_cur == BLK_T && w_t_ok)  w_next_state = RX_T;
            end
            default: w_next_state = RX_E;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= RX_INIT;
            r_rx_data   <= LBLOCK_R_DATA;
            r_rx_ctrl   <= LBLOCK_R_CTRL;
            r_valid     <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_valid <= 1'b0;
            if (w_lock_loss) begin
                r_state <= RX_INIT;
                if (bus.i_enable) begin
                    r_rx_data <= LBLOCK_R_DATA;
                    r_rx_ctrl <= LBLOCK_R_CTRL;
                    r_valid   <= 1'b1;
                end
            end else if (bus.i_enable && w_stage_full) begin
                r_state <= w_next_state;
                r_valid <= 1'b1;
                if (w_next_state == RX_E) begin
                    r_rx_data <= EBLOCK_R_DATA;
                    r_rx_ctrl <= EBLOCK_R_CTRL;
                    if (r_err_count != '1) r_err_count <= r_err_count + ERR_ONE;
                end else begin
                    r_rx_data <= w_stage_data;
                    r_rx_ctrl <= w_stage_ctrl;
                end
            end
        end
    end

    assign bus.o_rx_data   = r_rx_data;
    assign bus.o_rx_ctrl   = r_rx_ctrl;
    assign bus.o_valid     = r_valid;
    assign bus.o_state     = r_state;
    assign bus.o_err_count = r_err_count;

endmodule

// File: tb/tb_rx_decode_fsm.sv
// Directed bench for rx_decode_fsm: stimulus queues expected CGMII blocks,
// an independent monitor pops and compares each valid output.
module tb_rx_decode_fsm;
    import pcs_rx_pkg::*;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  c;
        logic [2:0]  s;
        logic [15:0] n;
    } exp_t;

    logic clk;
    logic rst;
    rx_decode_fsm_if bus ();

    rx_decode_fsm dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    exp_t        sb_q[$];
    int          n_cmp   = 0;
    int          n_fail  = 0;
    int          n_txn   = 0;
    bit          verbose = 1;
    logic [15:0] exp_cnt = '0;
    logic [63:0] prev_d  = '0;
    logic [7:0]  prev_c  = '0;
    int          seq     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: run did not complete, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    // Monitor: every valid output must match the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (!rst && bus.o_valid) begin
            n_cmp++;
            n_txn++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL txn%0d unexpected: got data=%h ctrl=%h state=%0d, required no output",
                         n_txn, bus.o_rx_data, bus.o_rx_ctrl, bus.o_state);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (bus.o_rx_data !== e.d || bus.o_rx_ctrl !== e.c ||
                    bus.o_state !== e.s || bus.o_err_count !== e.n) begin
                    n_fail++;
                    $display("FAIL txn%0d: got data=%h ctrl=%h state=%0d cnt=%0d, required data=%h ctrl=%h state=%0d cnt=%0d",
                             n_txn, bus.o_rx_data, bus.o_rx_ctrl, bus.o_state, bus.o_err_count,
                             e.d, e.c, e.s, e.n);
                end else if (verbose) begin
                    $display("txn%0d: data=%h ctrl=%h state=%0d cnt=%0d ok",
                             n_txn, bus.o_rx_data, bus.o_rx_ctrl, bus.o_state, bus.o_err_count);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end else begin
            $display("check %s: %h ok", name, act);
        end
    endtask

    // Present one block; when out=1 the previously staged block is expected
    // to emerge with destination state es (EBLOCK_R if es is RX_E).
    task automatic send(input logic [3:0] rt, input bit out, input logic [2:0] es);
        logic [63:0] d;
        logic [7:0]  c;
        exp_t        e;
        @(negedge clk);
        d = {$urandom, $urandom};
        c = 8'(seq * 37 + 5);
        seq++;
        if (out) begin
            if (es == 3'd4) begin
                if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
                e = '{d: EBLOCK_R_DATA, c: EBLOCK_R_CTRL, s: es, n: exp_cnt};
            end else begin
                e = '{d: prev_d, c: prev_c, s: es, n: exp_cnt};
            end
            sb_q.push_back(e);
        end
        bus.i_rx_data = d;
        bus.i_rx_ctrl = c;
        bus.i_r_type  = rt;
        bus.i_enable  = 1'b1;
        prev_d = d;
        prev_c = c;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.i_enable     = 1'b0;
        bus.i_block_lock = 1'b1;
        bus.i_hi_ber     = 1'b0;
    endtask

    task automatic lose_lock(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.i_block_lock = 1'b0;
            bus.i_enable     = 1'b1;
            e = '{d: LBLOCK_R_DATA, c: LBLOCK_R_CTRL, s: 3'd0, n: exp_cnt};
            sb_q.push_back(e);
        end
    endtask

    task automatic check_no_valid(input string name);
        @(posedge clk);
        #1;
        check(name, 64'(bus.o_valid), 64'd0);
    endtask

    initial begin
        rst              = 1'b1;
        bus.i_enable     = 1'b0;
        bus.i_rx_data    = '0;
        bus.i_rx_ctrl    = '0;
        bus.i_r_type     = '0;
        bus.i_block_lock = 1'b1;
        bus.i_hi_ber     = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", 64'(bus.o_state), 64'd0);
        check("reset_valid", 64'(bus.o_valid), 64'd0);
        check("reset_data", bus.o_rx_data, 64'h9C000001_9C000001);
        check("reset_ctrl", 64'(bus.o_rx_ctrl), 64'h88);
        check("reset_cnt", 64'(bus.o_err_count), 64'd0);
        rst = 1'b0;

        // Idle / packet / idle
        send(R_TYPE_C, 0, 3'd0);
        send(R_TYPE_C, 1, 3'd1);
        send(R_TYPE_S, 1, 3'd1);
        send(R_TYPE_D, 1, 3'd2);
        send(R_TYPE_D, 1, 3'd2);
        send(R_TYPE_T, 1, 3'd2);
        send(R_TYPE_C, 1, 3'd3);
        // T followed by D is rejected
        send(R_TYPE_S, 1, 3'd1);
        send(R_TYPE_D, 1, 3'd2);
        send(R_TYPE_T, 1, 3'd2);
        send(R_TYPE_D, 1, 3'd4);
        // Recovery from RX_E through D, T, C
        send(R_TYPE_T, 1, 3'd2);
        send(R_TYPE_C, 1, 3'd3);
        send(R_TYPE_C, 1, 3'd1);
        // Illegal r_type codes
        send(4'b0110, 1, 3'd1);
        send(4'b0000, 1, 3'd4);
        send(R_TYPE_C, 1, 3'd4);
        send(R_TYPE_C, 1, 3'd1);
        // Lock loss mid-packet with enable held
        send(R_TYPE_S, 1, 3'd1);
        send(R_TYPE_D, 1, 3'd2);
        lose_lock(3);
        idle();
        send(R_TYPE_C, 0, 3'd0);
        check_no_valid("relock_first_valid");
        send(R_TYPE_C, 1, 3'd1);
        send(R_TYPE_S, 1, 3'd1);
        // High BER pulse without enable still flushes
        @(negedge clk);
        bus.i_enable = 1'b0;
        bus.i_hi_ber = 1'b1;
        @(negedge clk);
        check("hiber_state", 64'(bus.o_state), 64'd0);
        bus.i_hi_ber = 1'b0;
        send(R_TYPE_C, 0, 3'd0);
        check_no_valid("hiber_first_valid");
        send(R_TYPE_S, 1, 3'd1);
        send(R_TYPE_D, 1, 3'd2);
        // Counter saturation
        send(4'b0000, 1, 3'd2);
        verbose = 0;
        for (int i = 0; i < 65540; i++) send(4'b0000, 1, 3'd4);
        verbose = 1;
        idle();
        @(posedge clk);
        #1;
        check("cnt_saturated", 64'(bus.o_err_count), 64'hFFFF);
        check("queue_drained", 64'(sb_q.size()), 64'd0);
        // Asynchronous reset between edges
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_state", 64'(bus.o_state), 64'd0);
        check("async_rst_valid", 64'(bus.o_valid), 64'd0);
        check("async_rst_data", bus.o_rx_data, 64'h9C000001_9C000001);
        check("async_rst_ctrl", 64'(bus.o_rx_ctrl), 64'h88);
        check("async_rst_cnt", 64'(bus.o_err_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
